// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - opcodes, state encodings and control-word codes for the multi-cycle control unit
package mc_cpu_pkg;

   localparam int OPC_W = 6;

   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IMMEX  = 4'd10,
      S_IMMWB  = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRC2_B     = 2'b00;
   localparam logic [1:0] SRC2_FOUR  = 2'b01;
   localparam logic [1:0] SRC2_IMM   = 2'b10;
   localparam logic [1:0] SRC2_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       id_sel;
      logic       mre;
      logic       mwe;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       alu_in1_sel;
      logic [1:0] alu_in2_sel;
      logic [1:0] alu_op;
      logic       branch;
      logic       branch_ne;
      logic       rf_we;
      logic       rf_dsel;
      logic       mto_rf_sel;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - state to control-word decoder; CU_MEMWAIT_EN gates FETCH IR/PC writes on mem_ready
// Every field defaults to 0 and reset forces the whole word to 0.
module mc_ctrl_outdec
   import mc_cpu_pkg::*;
#(
   parameter int              OP_W   = OPC_W,
   parameter logic [OP_W-1:0] OP_BEQ = OPC_BEQ
) (
   input  state_t          state,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   input  logic            reset,
   output ctrl_t           ctrl
);

   logic mem_go;
`ifdef CU_MEMWAIT_EN
   assign mem_go = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_go           = 1'b1;
`endif

   always_comb begin
      ctrl = '0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               ctrl.mre         = 1'b1;
               ctrl.ir_we       = mem_go;
               ctrl.pc_we       = mem_go;
               ctrl.alu_in2_sel = SRC2_FOUR;
            end
            S_DECODE: ctrl.alu_in2_sel = SRC2_IMMSH;
            S_MEMADR: begin
               ctrl.alu_in1_sel = 1'b1;
               ctrl.alu_in2_sel = SRC2_IMM;
            end
            S_MEMRD: begin
               ctrl.id_sel = 1'b1;
               ctrl.mre    = 1'b1;
            end
            S_MEMWB: begin
               ctrl.rf_we      = 1'b1;
               ctrl.mto_rf_sel = 1'b1;
            end
            S_MEMWR: begin
               ctrl.id_sel = 1'b1;
               ctrl.mwe    = 1'b1;
            end
            S_EXEC: begin
               ctrl.alu_in1_sel = 1'b1;
               ctrl.alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               ctrl.rf_we   = 1'b1;
               ctrl.rf_dsel = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_in1_sel = 1'b1;
               ctrl.alu_op      = ALUOP_SUB;
               ctrl.pc_sel      = PC_ALUOUT;
               ctrl.branch      = (op == OP_BEQ);
               ctrl.branch_ne   = (op != OP_BEQ);
            end
            S_JUMP: begin
               ctrl.pc_we  = 1'b1;
               ctrl.pc_sel = PC_JUMP;
            end
            S_IMMEX: begin
               ctrl.alu_in1_sel = 1'b1;
               ctrl.alu_in2_sel = SRC2_IMM;
            end
            S_IMMWB: ctrl.rf_we      = 1'b1;
            S_TRAP:  ctrl.illegal_op = 1'b1;
            default: ctrl = '0;
         endcase
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM; CU_MEMWAIT_EN adds memory wait states
// Holds only the state register; control outputs come from mc_ctrl_outdec.
module mc_control_fsm
   import mc_cpu_pkg::*;
#(
   parameter int              OP_W     = OPC_W,
   parameter logic [OP_W-1:0] OP_LW    = OPC_LW,
   parameter logic [OP_W-1:0] OP_SW    = OPC_SW,
   parameter logic [OP_W-1:0] OP_RTYPE = OPC_RTYPE,
   parameter logic [OP_W-1:0] OP_BEQ   = OPC_BEQ,
   parameter logic [OP_W-1:0] OP_BNE   = OPC_BNE,
   parameter logic [OP_W-1:0] OP_J     = OPC_J,
   parameter logic [OP_W-1:0] OP_ADDI  = OPC_ADDI
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] Op,
   input  logic            mem_ready,
   output logic            IDSel,
   output logic            MRE,
   output logic            MWE,
   output logic            IRWE,
   output logic            PCWE,
   output logic [1:0]      PCSel,
   output logic            ALUIn1Sel,
   output logic [1:0]      ALUIn2Sel,
   output logic [1:0]      ALUOp,
   output logic            Branch,
   output logic            BranchNE,
   output logic            RFWE,
   output logic            RFDSel,
   output logic            MtoRFSel,
   output logic            illegal_op,
   output logic [3:0]      state_o
);

   state_t state;
   ctrl_t  ctrl;
   logic   mem_go;

`ifdef CU_MEMWAIT_EN
   assign mem_go = mem_ready;
`else
   assign mem_go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  if (mem_go) state <= S_DECODE;
            S_DECODE: begin
               case (Op)
                  OP_LW, OP_SW:   state <= S_MEMADR;
                  OP_RTYPE:       state <= S_EXEC;
                  OP_BEQ, OP_BNE: state <= S_BRANCH;
                  OP_J:           state <= S_JUMP;
                  OP_ADDI:        state <= S_IMMEX;
                  default:        state <= S_TRAP;
               endcase
            end
            S_MEMADR: begin
               if (Op == OP_LW)      state <= S_MEMRD;
               else if (Op == OP_SW) state <= S_MEMWR;
               else                  state <= S_FETCH;
            end
            S_MEMRD:  if (mem_go) state <= S_MEMWB;
            S_MEMWR:  if (mem_go) state <= S_FETCH;
            S_EXEC:   state <= S_ALUWB;
            S_IMMEX:  state <= S_IMMWB;
            S_TRAP:   state <= S_TRAP;
            default:  state <= S_FETCH;
         endcase
      end
   end

   mc_ctrl_outdec #(
      .OP_W   (OP_W),
      .OP_BEQ (OP_BEQ)
   ) u_outdec (
      .state     (state),
      .op        (Op),
      .mem_ready (mem_ready),
      .reset     (reset),
      .ctrl      (ctrl)
   );

   assign IDSel      = ctrl.id_sel;
   assign MRE        = ctrl.mre;
   assign MWE        = ctrl.mwe;
   assign IRWE       = ctrl.ir_we;
   assign PCWE       = ctrl.pc_we;
   assign PCSel      = ctrl.pc_sel;
   assign ALUIn1Sel  = ctrl.alu_in1_sel;
   assign ALUIn2Sel  = ctrl.alu_in2_sel;
   assign ALUOp      = ctrl.alu_op;
   assign Branch     = ctrl.branch;
   assign BranchNE   = ctrl.branch_ne;
   assign RFWE       = ctrl.rf_we;
   assign RFDSel     = ctrl.rf_dsel;
   assign MtoRFSel   = ctrl.mto_rf_sel;
   assign illegal_op = ctrl.illegal_op;
   assign state_o    = reset ? 4'd0 : state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm; CU_MEMWAIT_EN enables the wait-state sequence
module tb_mc_control_fsm;

`ifdef CU_MEMWAIT_EN
   localparam bit MW = 1'b1;
`else
   localparam bit MW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Op = 6'h23;
   logic       mem_ready = 1'b1;
   logic       IDSel, MRE, MWE, IRWE, PCWE, ALUIn1Sel, Branch, BranchNE;
   logic       RFWE, RFDSel, MtoRFSel, illegal_op;
   logic [1:0] PCSel, ALUIn2Sel, ALUOp;
   logic [3:0] state_o;
   logic [21:0] got;

   int checks = 0;
   int errors = 0;
   int seq[$];

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .IDSel(IDSel), .MRE(MRE), .MWE(MWE), .IRWE(IRWE), .PCWE(PCWE),
      .PCSel(PCSel), .ALUIn1Sel(ALUIn1Sel), .ALUIn2Sel(ALUIn2Sel), .ALUOp(ALUOp),
      .Branch(Branch), .BranchNE(BranchNE), .RFWE(RFWE), .RFDSel(RFDSel),
      .MtoRFSel(MtoRFSel), .illegal_op(illegal_op), .state_o(state_o)
   );

   assign got = {IDSel, MRE, MWE, IRWE, PCWE, PCSel, ALUIn1Sel, ALUIn2Sel, ALUOp,
                 Branch, BranchNE, RFWE, RFDSel, MtoRFSel, illegal_op, state_o};

   // Expected outputs written straight from the per-state output list
   function automatic logic [21:0] exp_out(input int st, input logic [5:0] op, input logic mr);
      logic idsel, mre, mwe, irwe, pcwe, in1, br, brne, rfwe, rfd, m2r, ill;
      logic [1:0] pcsel, in2, aluop;
      logic [3:0] s4;
      {idsel, mre, mwe, irwe, pcwe, in1, br, brne, rfwe, rfd, m2r, ill} = '0;
      {pcsel, in2, aluop} = '0;
      s4 = st[3:0];
      case (st)
         0:  begin mre = 1; irwe = MW ? mr : 1'b1; pcwe = irwe; in2 = 2'b01; end
         1:  in2 = 2'b11;
         2:  begin in1 = 1; in2 = 2'b10; end
         3:  begin idsel = 1; mre = 1; end
         4:  begin rfwe = 1; m2r = 1; end
         5:  begin idsel = 1; mwe = 1; end
         6:  begin in1 = 1; aluop = 2'b10; end
         7:  begin rfwe = 1; rfd = 1; end
         8:  begin in1 = 1; aluop = 2'b01; pcsel = 2'b01; br = (op == 6'h04); brne = (op == 6'h05); end
         9:  begin pcwe = 1; pcsel = 2'b10; end
         10: begin in1 = 1; in2 = 2'b10; end
         11: rfwe = 1;
         12: ill = 1;
         default: s4 = 4'd0;
      endcase
      return {idsel, mre, mwe, irwe, pcwe, pcsel, in1, in2, aluop, br, brne, rfwe, rfd, m2r, ill, s4};
   endfunction

   // Path of an instruction, from the opcode's documented state sequence
   task automatic build_seq(input logic [5:0] op);
      seq = '{0, 1};
      case (op)
         6'h23:        begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         6'h2B:        begin seq.push_back(2); seq.push_back(5); end
         6'h00:        begin seq.push_back(6); seq.push_back(7); end
         6'h04, 6'h05: seq.push_back(8);
         6'h02:        seq.push_back(9);
         6'h08:        begin seq.push_back(10); seq.push_back(11); end
         default:      seq.push_back(12);
      endcase
   endtask

   task automatic check(input string name, input logic [21:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!MW) mem_ready = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic run_instr(input logic [5:0] op, input string tag);
      build_seq(op);
      Op = op;
      #1;
      foreach (seq[i]) begin
         check($sformatf("%s_c%0d", tag, i), exp_out(seq[i], op, mem_ready));
         step();
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      check({tag, "_rst_zero"}, 22'd0);
      step();
      check({tag, "_rst_hold"}, 22'd0);
      reset = 1'b0;
      #1;
      check({tag, "_rst_fetch"}, exp_out(0, Op, mem_ready));
   endtask

   typedef struct {
      logic [5:0] op;
      int         lat;
   } vec_t;

   vec_t vt[7];
   logic [5:0] legal[7];

   initial begin
      int cnt;
      logic [5:0] rop;
      vt[0] = '{6'h23, 5}; vt[1] = '{6'h2B, 4}; vt[2] = '{6'h00, 4};
      vt[3] = '{6'h08, 4}; vt[4] = '{6'h04, 3}; vt[5] = '{6'h05, 3};
      vt[6] = '{6'h02, 3};
      legal = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08};

      // Reset held two cycles with a load opcode present
      #2;
      check("reset_c0", 22'd0);
      step();
      check("reset_c1", 22'd0);
      step();
      check("reset_c2", 22'd0);
      reset = 1'b0;
      #1;
      check("reset_release_fetch", exp_out(0, Op, mem_ready));

      // Latency table measured from FETCH back to FETCH
      for (int i = 0; i < 7; i++) begin
         Op = vt[i].op;
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (state_o != 4'd0 && cnt < 20);
         check_int($sformatf("latency_op%h", vt[i].op), cnt, vt[i].lat);
      end

      run_instr(6'h23, "lw");
      run_instr(6'h04, "beq");
      run_instr(6'h05, "bne");

      // Illegal opcode traps and stays trapped
      run_instr(6'h3F, "trap");
      for (int i = 0; i < 10; i++) begin
         check($sformatf("trap_hold%0d", i), exp_out(12, Op, mem_ready));
         step();
      end
      do_reset("trap");

      // Reset arriving in MEMWB suppresses the register write
      Op = 6'h23;
      for (int i = 0; i < 4; i++) step();
      check("memwb_before_rst", exp_out(4, Op, mem_ready));
      reset = 1'b1;
      #1;
      check("memwb_rst_rfwe", {21'd0, RFWE} ^ 22'd0);
      check("memwb_rst_zero", 22'd0);
      step();
      reset = 1'b0;
      #1;
      check("memwb_rst_fetch", exp_out(0, Op, mem_ready));

`ifdef CU_MEMWAIT_EN
      // Store with FETCH and MEMWR wait states
      Op = 6'h2B;
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("mw_fetch_wait%0d", i), exp_out(0, Op, 1'b0));
         step();
      end
      mem_ready = 1'b1;
      #1;
      check("mw_fetch_go", exp_out(0, Op, 1'b1));
      step();
      check("mw_decode", exp_out(1, Op, 1'b1));
      step();
      check("mw_memadr", exp_out(2, Op, 1'b1));
      step();
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mw_memwr_wait%0d", i), exp_out(5, Op, 1'b0));
         step();
      end
      mem_ready = 1'b1;
      #1;
      check("mw_memwr_done", exp_out(5, Op, 1'b1));
      step();
      check("mw_back_fetch", exp_out(0, Op, 1'b1));
`endif

      // Random instruction stream against the path model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 8) rop = legal[$urandom_range(0, 6)];
         else rop = 6'($urandom);
         run_instr(rop, $sformatf("rnd%0d_op%h", n, rop));
         if (seq[seq.size() - 1] == 12) do_reset($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
